sub_core_scheduler: RTL and testbench
=====================================

// Module: sub_core_scheduler
// PURPOSE
//  Main-core-side controller for CORE_NUM sub cores: assigns fork requests to idle cores (round-robin),
//  pulses exec_requested/requested_pc, tracks busy/ended per core, reports join completion, and
//  arbitrates the single result-read path (fetch_addr -> fetch_result) across cores, one read at a time.
// PARAMETERS
//  CORE_NUM  4  number of sub cores managed (2..8); IDX_W = $clog2(CORE_NUM)
//  RD_LAT    1  cycles from fetch_addr valid to fetch_result valid at a sub core (1..3)
// PORTS
//  clk            in   1            single clock, all logic on posedge
//  rst            in   1            synchronous, active-high reset
//  fork_valid     in   1            main requests a new sub-core run
//  fork_pc        in   32           start PC of requested run
//  fork_ready     out  1            an idle core exists; fork accepted when valid&ready
//  fork_core      out  IDX_W        core index chosen (valid with fork_valid&fork_ready)
//  join_valid     in   1            main waits on join_mask
//  join_mask      in   CORE_NUM     cores to wait for
//  join_done      out  1            one-cycle pulse: all masked cores idle
//  busy           out  CORE_NUM     per-core running flag
//  exec_requested out  CORE_NUM     one-cycle launch pulse per core
//  requested_pc   out  32           PC broadcast to all cores, valid with any exec_requested bit
//  ended          in   CORE_NUM     per-core ended flag from sub cores
//  rd_valid       in   1            main requests a result word
//  rd_core        in   IDX_W        core to read
//  rd_addr        in   32           word address within that core's memory
//  rd_ready       out  1            read FSM idle
//  rd_resp_valid  out  1            one-cycle pulse with rd_resp_data
//  rd_resp_data   out  32           returned word
//  fetch_addr     out  32           broadcast address to all cores
//  fetch_result   in   32*CORE_NUM  packed per-core read data, core i at [32*i+:32]
// BEHAVIOUR
//  Reset: busy=0, exec_requested=0, requested_pc=0, join_done=0, rd_resp_valid=0, rd_resp_data=0,
//   fetch_addr=0, rr pointer=0, read FSM RD_IDLE, every slot S_IDLE. Reset mid-run abandons cores (no abort).
//  Slot FSM per core: S_IDLE -fork hit-> S_LAUNCH (exec_requested[i]=1 exactly this cycle, busy=1)
//   -> S_RUN (ended[i] ignored in S_LAUNCH; stale ended=1 from prior run is masked) -ended[i]=1-> S_IDLE.
//  Fork: fork_ready = |(~busy). Chosen core = first idle index at/after rr pointer, wrapping CORE_NUM-1 -> 0.
//   On accept: requested_pc<=fork_pc, rr pointer<=chosen+1 (wrap). One fork per cycle max.
//   busy[i] set in the accept cycle+1; core freed on ended same cycle as a new fork: the freed core is not
//   eligible until the next cycle (busy cleared registered).
//  Join: while join_valid, join_done pulses in the first cycle (join_mask & busy)==0; join_mask==0 -> pulse
//   next cycle. join_done stays low until join_valid drops and is reasserted (single pulse per request).
//  Read FSM: RD_IDLE -rd_valid-> RD_WAIT (fetch_addr<=rd_addr, latch rd_core, cnt=RD_LAT) -> cnt==0 ->
//   RD_IDLE with rd_resp_valid=1, rd_resp_data=fetch_result[32*core+:32]. Total latency RD_LAT+1.
//   rd_ready=1 only in RD_IDLE. rd_core>=CORE_NUM returns 0. Reading a busy core is allowed (data undefined).
//  fetch_addr holds its value between reads.
// CONFIGURATION
//  SUB_SCHED_PERF_EN defined: extra out port perf_cycles[32*CORE_NUM]; counter i increments each cycle
//   busy[i]=1, saturates at 32'hFFFF_FFFF, cleared by rst only. Undefined: port and counters absent.
// STRUCTURE
//  Package sub_sched_pkg: slot_state_t {S_IDLE,S_LAUNCH,S_RUN}, rd_state_t {RD_IDLE,RD_WAIT}, MAX_CORES=8.
//  Sub-module sub_core_slot (one per core, generate loop): inputs launch, ended; outputs busy,
//   exec_requested; holds slot FSM (and perf counter under SUB_SCHED_PERF_EN).
//  Top holds rr pick logic, join logic, read FSM.
// TESTING
//  1 rst; fork_pc=0x100 x5 back-to-back, CORE_NUM=4 -> cores 0,1,2,3 launched, fork_ready=0 on 5th.
//  2 core 2 ended=1 held high before launch; fork to core 2 -> busy[2] stays 1 through S_LAUNCH, clears
//    only on ended after ended has dropped/rerisen.
//  3 join_mask=4'b0101, end core0 then core2 -> join_done single pulse the cycle after core2 idle.
//  4 rd_core=3, rd_addr=0x40, fetch_result[127:96]=0xDEADBEEF, RD_LAT=1 -> rd_resp_valid 2 cycles later
//    with 0xDEADBEEF; rd_ready low in between.
//  5 rr wrap: pointer=3, cores 3 busy,0 idle -> fork picks 0; ended and fork same cycle -> freed core skipped.
//  6 SUB_SCHED_PERF_EN: core1 runs 10 cycles -> perf_cycles[63:32]=10; rst mid-run -> all outputs reset.

Source files
------------

// File: rtl/sub_sched_pkg.sv
// Shared types for the sub-core scheduler: per-core slot states and read-path states.
package sub_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN
  } slot_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_WAIT
  } rd_state_t;

  localparam int MAX_CORES = 8;

endpackage

// File: rtl/sub_core_slot.sv
// One sub-core slot: launch/run/idle tracking with a registered launch pulse.
// With SUB_SCHED_PERF_EN defined it also keeps a saturating busy-cycle counter.
module sub_core_slot
  import sub_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        launch,
  input  logic        ended,
  output logic        busy,
  output logic        exec_requested
`ifdef SUB_SCHED_PERF_EN
  ,
  output logic [31:0] perf_cnt
`endif
);

  slot_state_t state_q, state_d;
  logic        busy_q, busy_d;
  logic        exec_q, exec_d;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    exec_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_LAUNCH;
          busy_d  = 1'b1;
          exec_d  = 1'b1;
        end
      end
      // ended is ignored here so a level left over from the previous run cannot retire the new one
      S_LAUNCH: begin
        state_d = S_RUN;
        busy_d  = 1'b1;
      end
      S_RUN: begin
        if (ended) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      exec_q  <= exec_d;
    end
  end

  assign busy           = busy_q;
  assign exec_requested = exec_q;

`ifdef SUB_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (busy_q && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= 32'd0;
    else     perf_q <= perf_d;
  end

  assign perf_cnt = perf_q;
`endif

endmodule

// File: rtl/sub_core_scheduler.sv
// Main-core-side scheduler: round-robin fork dispatch, join detection and a single shared result-read path.
// Define SUB_SCHED_PERF_EN to add per-core busy-cycle counters on perf_cycles.
module sub_core_scheduler
  import sub_sched_pkg::*;
#(
  parameter  int CORE_NUM = 4,
  parameter  int RD_LAT   = 1,
  localparam int IDX_W    = $clog2(CORE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fork_valid,
  input  logic [31:0]           fork_pc,
  output logic                  fork_ready,
  output logic [IDX_W-1:0]      fork_core,
  input  logic                  join_valid,
  input  logic [CORE_NUM-1:0]   join_mask,
  output logic                  join_done,
  output logic [CORE_NUM-1:0]   busy,
  output logic [CORE_NUM-1:0]   exec_requested,
  output logic [31:0]           requested_pc,
  input  logic [CORE_NUM-1:0]   ended,
  input  logic                  rd_valid,
  input  logic [IDX_W-1:0]      rd_core,
  input  logic [31:0]           rd_addr,
  output logic                  rd_ready,
  output logic                  rd_resp_valid,
  output logic [31:0]           rd_resp_data,
  output logic [31:0]           fetch_addr,
  input  logic [32*CORE_NUM-1:0] fetch_result
`ifdef SUB_SCHED_PERF_EN
  ,
  output logic [32*CORE_NUM-1:0] perf_cycles
`endif
);

  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  logic [CORE_NUM-1:0] busy_w;
  logic [CORE_NUM-1:0] launch_w;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic                fork_fire;
  int                  cand;

  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [31:0]         req_pc_q, req_pc_d;

  // Round-robin pick: first idle core at or after the pointer, wrapping to 0
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < CORE_NUM; k++) begin
      cand = (int'(rr_q) + k) % CORE_NUM;
      if (!pick_found && !busy_w[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign fork_ready = |(~busy_w);
  assign fork_core  = pick_idx;
  assign fork_fire  = fork_valid && fork_ready;

  always_comb begin
    rr_d     = rr_q;
    req_pc_d = req_pc_q;
    if (fork_fire) begin
      req_pc_d = fork_pc;
      rr_d     = (pick_idx == IDX_W'(CORE_NUM - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      req_pc_q <= 32'd0;
    end else begin
      rr_q     <= rr_d;
      req_pc_q <= req_pc_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CORE_NUM; gi++) begin : g_slot
      assign launch_w[gi] = fork_fire && (pick_idx == IDX_W'(gi));
      sub_core_slot u_slot (
        .clk            (clk),
        .rst            (rst),
        .launch         (launch_w[gi]),
        .ended          (ended[gi]),
        .busy           (busy_w[gi]),
        .exec_requested (exec_requested[gi])
`ifdef SUB_SCHED_PERF_EN
        ,
        .perf_cnt       (perf_cycles[32*gi +: 32])
`endif
      );
    end
  endgenerate

  assign busy         = busy_w;
  assign requested_pc = req_pc_q;

  // Join: one pulse per join_valid assertion, re-armed when join_valid drops
  logic join_done_q, join_done_d;
  logic join_fired_q, join_fired_d;

  always_comb begin
    join_done_d  = join_valid && !join_fired_q && ((join_mask & busy_w) == '0);
    join_fired_d = join_valid ? (join_fired_q || join_done_d) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      join_done_q  <= 1'b0;
      join_fired_q <= 1'b0;
    end else begin
      join_done_q  <= join_done_d;
      join_fired_q <= join_fired_d;
    end
  end

  assign join_done = join_done_q;

  // Shared read path: one outstanding read, RD_LAT+1 cycles from accept to response
  rd_state_t          rd_state_q, rd_state_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0]   rd_core_q, rd_core_d;
  logic [31:0]        fetch_addr_q, fetch_addr_d;
  logic               rd_resp_valid_q, rd_resp_valid_d;
  logic [31:0]        rd_resp_data_q, rd_resp_data_d;
  logic [31:0]        sel_data;

  always_comb begin
    sel_data = 32'd0;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (rd_core_q == IDX_W'(i)) sel_data = fetch_result[32*i +: 32];
    end
  end

  always_comb begin
    rd_state_d      = rd_state_q;
    rd_cnt_d        = rd_cnt_q;
    rd_core_d       = rd_core_q;
    fetch_addr_d    = fetch_addr_q;
    rd_resp_valid_d = 1'b0;
    rd_resp_data_d  = rd_resp_data_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_valid) begin
          rd_state_d   = RD_WAIT;
          fetch_addr_d = rd_addr;
          rd_core_d    = rd_core;
          rd_cnt_d     = CNT_W'(RD_LAT);
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q == '0) begin
          rd_state_d      = RD_IDLE;
          rd_resp_valid_d = 1'b1;
          rd_resp_data_d  = sel_data;
        end else begin
          rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q      <= RD_IDLE;
      rd_cnt_q        <= '0;
      rd_core_q       <= '0;
      fetch_addr_q    <= 32'd0;
      rd_resp_valid_q <= 1'b0;
      rd_resp_data_q  <= 32'd0;
    end else begin
      rd_state_q      <= rd_state_d;
      rd_cnt_q        <= rd_cnt_d;
      rd_core_q       <= rd_core_d;
      fetch_addr_q    <= fetch_addr_d;
      rd_resp_valid_q <= rd_resp_valid_d;
      rd_resp_data_q  <= rd_resp_data_d;
    end
  end

  assign rd_ready      = (rd_state_q == RD_IDLE);
  assign rd_resp_valid = rd_resp_valid_q;
  assign rd_resp_data  = rd_resp_data_q;
  assign fetch_addr    = fetch_addr_q;

endmodule

// File: tb/tb_sub_core_scheduler.sv
// Directed bench for sub_core_scheduler (CORE_NUM=4, RD_LAT=1); perf checks active under SUB_SCHED_PERF_EN.
module tb_sub_core_scheduler;

  localparam int CORE_NUM = 4;
  localparam int RD_LAT   = 1;

  logic         clk;
  logic         rst;
  logic         fork_valid;
  logic [31:0]  fork_pc;
  logic         fork_ready;
  logic [1:0]   fork_core;
  logic         join_valid;
  logic [3:0]   join_mask;
  logic         join_done;
  logic [3:0]   busy;
  logic [3:0]   exec_requested;
  logic [31:0]  requested_pc;
  logic [3:0]   ended;
  logic         rd_valid;
  logic [1:0]   rd_core;
  logic [31:0]  rd_addr;
  logic         rd_ready;
  logic         rd_resp_valid;
  logic [31:0]  rd_resp_data;
  logic [31:0]  fetch_addr;
  logic [127:0] fetch_result;
`ifdef SUB_SCHED_PERF_EN
  logic [127:0] perf_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sub_core_scheduler #(.CORE_NUM(CORE_NUM), .RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .fork_valid     (fork_valid),
    .fork_pc        (fork_pc),
    .fork_ready     (fork_ready),
    .fork_core      (fork_core),
    .join_valid     (join_valid),
    .join_mask      (join_mask),
    .join_done      (join_done),
    .busy           (busy),
    .exec_requested (exec_requested),
    .requested_pc   (requested_pc),
    .ended          (ended),
    .rd_valid       (rd_valid),
    .rd_core        (rd_core),
    .rd_addr        (rd_addr),
    .rd_ready       (rd_ready),
    .rd_resp_valid  (rd_resp_valid),
    .rd_resp_data   (rd_resp_data),
    .fetch_addr     (fetch_addr),
    .fetch_result   (fetch_result)
`ifdef SUB_SCHED_PERF_EN
    ,
    .perf_cycles    (perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    fork_valid   = 1'b0;
    fork_pc      = 32'd0;
    join_valid   = 1'b0;
    join_mask    = 4'd0;
    ended        = 4'd0;
    rd_valid     = 1'b0;
    rd_core      = 2'd0;
    rd_addr      = 32'd0;
    fetch_result = {32'hDEADBEEF, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    tick();
    tick();

    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_exec", 32'(exec_requested), 32'h0);
    check_val("rst_pc", requested_pc, 32'h0);
    check_val("rst_join", 32'(join_done), 32'h0);
    check_val("rst_rvalid", 32'(rd_resp_valid), 32'h0);
    check_val("rst_rdata", rd_resp_data, 32'h0);
    check_val("rst_faddr", fetch_addr, 32'h0);
    check_val("rst_fready", 32'(fork_ready), 32'h1);
    check_val("rst_rready", 32'(rd_ready), 32'h1);
    rst = 1'b0;

    // 1: five back-to-back forks fill cores 0..3, fifth is refused
    fork_valid = 1'b1;
    fork_pc    = 32'h100;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("t1_core%0d", k), 32'(fork_core), k);
      check_val($sformatf("t1_ready%0d", k), 32'(fork_ready), 32'h1);
      tick();
      check_val($sformatf("t1_exec%0d", k), 32'(exec_requested), 32'h1 << k);
      check_val($sformatf("t1_busy%0d", k), 32'(busy), (32'h2 << k) - 1);
      check_val($sformatf("t1_pc%0d", k), requested_pc, 32'h100);
    end
    check_val("t1_ready_full", 32'(fork_ready), 32'h0);
    tick();
    check_val("t1_exec_none", 32'(exec_requested), 32'h0);
    check_val("t1_busy_full", 32'(busy), 32'hF);
    fork_valid = 1'b0;

    // 3: join on cores 0 and 2
    join_valid = 1'b1;
    join_mask  = 4'b0101;
    tick();
    check_val("t3_wait0", 32'(join_done), 32'h0);
    ended = 4'b0001;
    tick();
    ended = 4'b0000;
    check_val("t3_busy_c0", 32'(busy), 32'hE);
    check_val("t3_wait1", 32'(join_done), 32'h0);
    tick();
    check_val("t3_wait2", 32'(join_done), 32'h0);
    ended = 4'b0100;
    tick();
    ended = 4'b0000;
    check_val("t3_busy_c2", 32'(busy), 32'hA);
    check_val("t3_wait3", 32'(join_done), 32'h0);
    tick();
    check_val("t3_pulse", 32'(join_done), 32'h1);
    tick();
    check_val("t3_single", 32'(join_done), 32'h0);
    tick();
    check_val("t3_single2", 32'(join_done), 32'h0);
    join_valid = 1'b0;
    tick();

    // empty mask pulses the cycle after the request
    join_valid = 1'b1;
    join_mask  = 4'b0000;
    tick();
    check_val("t3_empty", 32'(join_done), 32'h1);
    tick();
    check_val("t3_empty_once", 32'(join_done), 32'h0);
    join_valid = 1'b0;

    // 5: round-robin wrap and freed-core exclusion (busy=1010, rr=0)
    fork_valid = 1'b1;
    fork_pc    = 32'h200;
    check_val("t5_pick0", 32'(fork_core), 32'h0);
    tick();
    check_val("t5_pc200", requested_pc, 32'h200);
    fork_pc = 32'h300;
    check_val("t5_pick2", 32'(fork_core), 32'h2);
    tick();
    check_val("t5_exec2", 32'(exec_requested), 32'h4);
    check_val("t5_full", 32'(fork_ready), 32'h0);
    fork_valid = 1'b0;
    tick();
    ended = 4'b0001;
    tick();
    check_val("t5_busy_e", 32'(busy), 32'hE);
    ended      = 4'b1000;
    fork_valid = 1'b1;
    fork_pc    = 32'h400;
    check_val("t5_wrap", 32'(fork_core), 32'h0);
    tick();
    ended      = 4'b0000;
    fork_valid = 1'b0;
    check_val("t5_busy_7", 32'(busy), 32'h7);
    check_val("t5_exec0", 32'(exec_requested), 32'h1);
    check_val("t5_pc400", requested_pc, 32'h400);
    check_val("t5_next3", 32'(fork_core), 32'h3);

    // 2: stale ended on core 2 must not retire the new run
    ended = 4'b0100;
    tick();
    check_val("t2_free2", 32'(busy), 32'h3);
    fork_valid = 1'b1;
    fork_pc    = 32'h500;
    check_val("t2_pick2", 32'(fork_core), 32'h2);
    tick();
    fork_valid = 1'b0;
    check_val("t2_launch", 32'(busy), 32'h7);
    check_val("t2_exec", 32'(exec_requested), 32'h4);
    tick();
    check_val("t2_masked", 32'(busy), 32'h7);
    ended = 4'b0000;
    tick();
    check_val("t2_run0", 32'(busy), 32'h7);
    tick();
    check_val("t2_run1", 32'(busy), 32'h7);
    ended = 4'b0100;
    tick();
    ended = 4'b0000;
    check_val("t2_end", 32'(busy), 32'h3);

    // 4: read core 3 word
    rd_valid = 1'b1;
    rd_core  = 2'd3;
    rd_addr  = 32'h40;
    check_val("t4_ready", 32'(rd_ready), 32'h1);
    tick();
    rd_valid = 1'b0;
    check_val("t4_addr", fetch_addr, 32'h40);
    check_val("t4_busy0", 32'(rd_ready), 32'h0);
    check_val("t4_nv0", 32'(rd_resp_valid), 32'h0);
    tick();
    check_val("t4_busy1", 32'(rd_ready), 32'h0);
    check_val("t4_nv1", 32'(rd_resp_valid), 32'h0);
    tick();
    check_val("t4_valid", 32'(rd_resp_valid), 32'h1);
    check_val("t4_data", rd_resp_data, 32'hDEADBEEF);
    check_val("t4_ready2", 32'(rd_ready), 32'h1);
    tick();
    check_val("t4_pulse", 32'(rd_resp_valid), 32'h0);
    check_val("t4_hold", fetch_addr, 32'h40);
    rd_valid = 1'b1;
    rd_core  = 2'd1;
    rd_addr  = 32'h80;
    tick();
    rd_valid = 1'b0;
    tick();
    tick();
    check_val("t4_valid1", 32'(rd_resp_valid), 32'h1);
    check_val("t4_data1", rd_resp_data, 32'h2222_2222);
    check_val("t4_addr1", fetch_addr, 32'h80);

    // 6: reset mid-run abandons everything
    rst        = 1'b1;
    fork_valid = 1'b1;
    fork_pc    = 32'h999;
    tick();
    check_val("t6_busy", 32'(busy), 32'h0);
    check_val("t6_exec", 32'(exec_requested), 32'h0);
    check_val("t6_pc", requested_pc, 32'h0);
    check_val("t6_faddr", fetch_addr, 32'h0);
    check_val("t6_rdata", rd_resp_data, 32'h0);
    check_val("t6_rready", 32'(rd_ready), 32'h1);
    check_val("t6_rr", 32'(fork_core), 32'h0);
`ifdef SUB_SCHED_PERF_EN
    check_val("t6_perf0", perf_cycles[31:0], 32'h0);
`endif
    rst     = 1'b0;
    fork_pc = 32'h600;
    tick();
    fork_pc = 32'h700;
    check_val("t6_pick1", 32'(fork_core), 32'h1);
    tick();
    fork_valid = 1'b0;
    check_val("t6_busy3", 32'(busy), 32'h3);
    for (int k = 0; k < 9; k++) tick();
    ended = 4'b0010;
    tick();
    ended = 4'b0000;
    check_val("t6_c1_done", 32'(busy), 32'h1);
    tick();
`ifdef SUB_SCHED_PERF_EN
    check_val("t6_perf_c1", perf_cycles[63:32], 32'd10);
    check_val("t6_perf_c0", perf_cycles[31:0], 32'd12);
    check_val("t6_perf_c2", perf_cycles[95:64], 32'd0);
`endif
    check_val("t6_busy_end", 32'(busy), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
